// File: rtl/vc_d_arbiter.sv
// Virtual-channel to destination arbiter: strict-priority pop from VC0/VC1, one-cycle
// steer into D0/D1 by word MSB, plus the threshold configuration state machine.
module vc_d_arbiter #(
    parameter int DATA_SIZE  = 6,
    parameter int AF_DEFAULT = 12,
    parameter int AE_DEFAULT = 2
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [DATA_SIZE-1:0] afd_in,
    input  logic [DATA_SIZE-1:0] aed_in,
    input  logic                 fifo_empty_vc0,
    input  logic                 fifo_empty_vc1,
    input  logic [DATA_SIZE-1:0] data_vc0,
    input  logic [DATA_SIZE-1:0] data_vc1,
    input  logic                 fifo_pause_d0,
    input  logic                 fifo_pause_d1,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic [DATA_SIZE-1:0] afd,
    output logic [DATA_SIZE-1:0] aed,
    output logic [1:0]           state,
    output logic                 idle
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] afd_q, aed_q;
    logic                 pending_q, sel_q;
    logic                 go, pend_eff;
    logic [DATA_SIZE-1:0] mux_data;

    // A raised init stops new pops in the same cycle; a held reset also discards the pending push.
    always_comb begin
        go       = reset_L && !init && (state_q == ST_ACTIVE) && !fifo_pause_d0 && !fifo_pause_d1;
        pop_vc0  = go && !fifo_empty_vc0;
        pop_vc1  = go && fifo_empty_vc0 && !fifo_empty_vc1;
        pend_eff = reset_L && pending_q;
        mux_data = sel_q ? data_vc1 : data_vc0;
        data_out = pend_eff ? mux_data : '0;
        push_d0  = pend_eff && !mux_data[DATA_SIZE-1];
        push_d1  = pend_eff && mux_data[DATA_SIZE-1];
    end

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_RESET:  state_d = ST_INIT;
                ST_INIT:   state_d = ST_IDLE;
                ST_IDLE:   if (!fifo_empty_vc0 || !fifo_empty_vc1) state_d = ST_ACTIVE;
                ST_ACTIVE: if (fifo_empty_vc0 && fifo_empty_vc1 && !pending_q && !pop_vc0 && !pop_vc1)
                               state_d = ST_IDLE;
                default:   state_d = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q   <= ST_RESET;
            afd_q     <= DATA_SIZE'(AF_DEFAULT);
            aed_q     <= DATA_SIZE'(AE_DEFAULT);
            pending_q <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pop_vc0 || pop_vc1;
            if (pop_vc0 || pop_vc1) begin
                sel_q <= pop_vc1;
            end
            if (init) begin
                afd_q <= afd_in;
                aed_q <= aed_in;
            end
        end
    end

    assign afd   = afd_q;
    assign aed   = aed_q;
    assign state = state_q;
    assign idle  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_vc_d_arbiter.sv
// Bench for vc_d_arbiter: queue-based VC FIFO environment, behavioural model checked every
// cycle, directed scenarios with literal expectations, then a randomized run.
module tb_vc_d_arbiter;

    logic       clk = 1'b0;
    logic       reset_L, init;
    logic [5:0] afd_in, aed_in;
    logic       fifo_empty_vc0, fifo_empty_vc1;
    logic [5:0] data_vc0, data_vc1;
    logic       fifo_pause_d0, fifo_pause_d1;
    logic       pop_vc0, pop_vc1, push_d0, push_d1;
    logic [5:0] data_out, afd, aed;
    logic [1:0] state;
    logic       idle;

    vc_d_arbiter #(.DATA_SIZE(6), .AF_DEFAULT(12), .AE_DEFAULT(2)) dut (
        .clk(clk), .reset_L(reset_L), .init(init), .afd_in(afd_in), .aed_in(aed_in),
        .fifo_empty_vc0(fifo_empty_vc0), .fifo_empty_vc1(fifo_empty_vc1),
        .data_vc0(data_vc0), .data_vc1(data_vc1),
        .fifo_pause_d0(fifo_pause_d0), .fifo_pause_d1(fifo_pause_d1),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
        .data_out(data_out), .afd(afd), .aed(aed), .state(state), .idle(idle)
    );

    always #5 clk = ~clk;

    // Environment: VC FIFO contents and words staged to be written on the next step.
    logic [5:0] vc0_q[$], vc1_q[$], add0_q[$], add1_q[$];
    logic       nx_rst, nx_init, nx_pd0, nx_pd1;
    logic [5:0] nx_afd, nx_aed;
    logic       s_pop0, s_pop1;

    // Model: state number, thresholds, and the one word expected to be pushed next cycle.
    int         m_state;
    logic [5:0] m_afd, m_aed, m_word;
    logic       m_pend, e_pop0, e_pop1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        logic       old_pend, eff;
        logic [5:0] exp_data;
        @(posedge clk);
        #1;
        old_pend = m_pend;
        if (!reset_L) begin
            m_state = 0; m_afd = 6'd12; m_aed = 6'd2; m_pend = 1'b0;
        end else begin
            m_pend = e_pop0 || e_pop1;
            if (e_pop0) m_word = vc0_q[0];
            else if (e_pop1) m_word = vc1_q[0];
            if (init) begin
                m_state = 1; m_afd = afd_in; m_aed = aed_in;
            end else begin
                case (m_state)
                    0: m_state = 1;
                    1: m_state = 2;
                    2: if (vc0_q.size() > 0 || vc1_q.size() > 0) m_state = 3;
                    default: if (vc0_q.size() == 0 && vc1_q.size() == 0 && !old_pend && !e_pop0 && !e_pop1)
                                 m_state = 2;
                endcase
            end
        end
        // The FIFOs answer the DUT's actual pops with registered data.
        if (s_pop0 && vc0_q.size() > 0) data_vc0 = vc0_q.pop_front();
        if (s_pop1 && vc1_q.size() > 0) data_vc1 = vc1_q.pop_front();
        while (add0_q.size() > 0) vc0_q.push_back(add0_q.pop_front());
        while (add1_q.size() > 0) vc1_q.push_back(add1_q.pop_front());
        reset_L = nx_rst; init = nx_init; afd_in = nx_afd; aed_in = nx_aed;
        fifo_pause_d0 = nx_pd0; fifo_pause_d1 = nx_pd1;
        fifo_empty_vc0 = (vc0_q.size() == 0);
        fifo_empty_vc1 = (vc1_q.size() == 0);
        @(negedge clk);
        e_pop0 = reset_L && !init && m_state == 3 && !fifo_pause_d0 && !fifo_pause_d1 && vc0_q.size() > 0;
        e_pop1 = reset_L && !init && m_state == 3 && !fifo_pause_d0 && !fifo_pause_d1 &&
                 vc0_q.size() == 0 && vc1_q.size() > 0;
        eff      = reset_L && m_pend;
        exp_data = eff ? m_word : 6'd0;
        chk("pop_vc0", pop_vc0, e_pop0);
        chk("pop_vc1", pop_vc1, e_pop1);
        chk("push_d0", push_d0, eff && !m_word[5]);
        chk("push_d1", push_d1, eff && m_word[5]);
        chk("data_out", data_out, exp_data);
        chk("afd", afd, m_afd);
        chk("aed", aed, m_aed);
        chk("state", state, m_state);
        chk("idle", idle, m_state == 2);
        s_pop0 = pop_vc0;
        s_pop1 = pop_vc1;
        if (push_d0 || push_d1)
            $display("push d%0d data=%02h t=%0t", push_d1, data_out, $time);
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b0; afd_in = '0; aed_in = '0;
        fifo_empty_vc0 = 1'b1; fifo_empty_vc1 = 1'b1; data_vc0 = '0; data_vc1 = '0;
        fifo_pause_d0 = 1'b0; fifo_pause_d1 = 1'b0;
        nx_rst = 1'b0; nx_init = 1'b0; nx_afd = '0; nx_aed = '0; nx_pd0 = 1'b0; nx_pd1 = 1'b0;
        s_pop0 = 1'b0; s_pop1 = 1'b0;
        m_state = 0; m_afd = 6'd12; m_aed = 6'd2; m_word = '0; m_pend = 1'b0;
        e_pop0 = 1'b0; e_pop1 = 1'b0;

        // Reset, then configure thresholds 10/3.
        step(); step();
        chk("t1_state", state, 0); chk("t1_afd", afd, 12); chk("t1_aed", aed, 2);
        chk("t1_pop", {pop_vc0, pop_vc1, push_d0, push_d1}, 0);
        nx_rst = 1'b1; nx_init = 1'b1; nx_afd = 6'd10; nx_aed = 6'd3; step();
        nx_init = 1'b0; step();
        chk("t1_init_state", state, 1); chk("t1_afd_cap", afd, 10); chk("t1_aed_cap", aed, 3);
        step();
        chk("t1_idle_state", state, 2); chk("t1_idle", idle, 1);

        // Two VC0 words steered by MSB.
        add0_q.push_back(6'h05); add0_q.push_back(6'h25); step();
        step(); chk("t2_active", state, 3); chk("t2_pop_a", pop_vc0, 1);
        step(); chk("t2_push_d0", push_d0, 1); chk("t2_data_a", data_out, 6'h05); chk("t2_pop_b", pop_vc0, 1);
        step(); chk("t2_push_d1", push_d1, 1); chk("t2_data_b", data_out, 6'h25); chk("t2_pop_c", pop_vc0, 0);
        step(); step(); chk("t2_back_idle", state, 2);

        // VC0 priority over VC1.
        add0_q.push_back(6'h01); add0_q.push_back(6'h02);
        add1_q.push_back(6'h21); add1_q.push_back(6'h03); step();
        step(); chk("t3_pop0_a", pop_vc0, 1); chk("t3_pop1_a", pop_vc1, 0);
        step(); chk("t3_pop1_b", pop_vc1, 0); chk("t3_data_a", data_out, 6'h01);
        step(); chk("t3_pop1_c", pop_vc1, 1); chk("t3_data_b", data_out, 6'h02);
        step(); chk("t3_pop1_d", pop_vc1, 1); chk("t3_data_c", data_out, 6'h21); chk("t3_push_d1", push_d1, 1);
        step(); chk("t3_data_d", data_out, 6'h03); chk("t3_push_d0", push_d0, 1);
        step(); step();

        // Pause after a pop: the issued word still lands, no new pops.
        add0_q.push_back(6'h11); add0_q.push_back(6'h12); step();
        step(); chk("t4_pop", pop_vc0, 1);
        nx_pd1 = 1'b1; step(); chk("t4_push_paused", push_d0, 1); chk("t4_data", data_out, 6'h11);
        chk("t4_nopop", pop_vc0, 0);
        step(); chk("t4_nopop2", pop_vc0, 0); chk("t4_nopush", push_d0, 0);
        nx_pd1 = 1'b0; step(); chk("t4_resume", pop_vc0, 1);
        step(); chk("t4_data2", data_out, 6'h12);
        step(); step();

        // Reset right after a pop discards the push.
        add0_q.push_back(6'h30); step();
        step(); chk("t5_pop", pop_vc0, 1);
        nx_rst = 1'b0; step();
        nx_rst = 1'b1; step();
        chk("t5_state", state, 0); chk("t5_afd", afd, 12); chk("t5_aed", aed, 2);
        chk("t5_nopush", push_d1, 0); chk("t5_data", data_out, 0);
        step(); step(); chk("t5_idle", state, 2);

        // init raised while active.
        add0_q.push_back(6'h01); add0_q.push_back(6'h02); add0_q.push_back(6'h03); step();
        step(); chk("t6_pop", pop_vc0, 1);
        nx_init = 1'b1; nx_afd = 6'd20; nx_aed = 6'd5; step();
        chk("t6_stop", pop_vc0, 0); chk("t6_push", push_d0, 1); chk("t6_data", data_out, 6'h01);
        nx_init = 1'b0; step(); chk("t6_init", state, 1); chk("t6_afd", afd, 20); chk("t6_aed", aed, 5);
        step(); chk("t6_idle", state, 2);
        step(); chk("t6_active", state, 3); chk("t6_resume", pop_vc0, 1);
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic with occasional pause, init and reset.
        for (int c = 0; c < 3000; c++) begin
            nx_rst  = ($urandom_range(0, 199) != 0);
            nx_init = ($urandom_range(0, 99) == 0);
            nx_afd  = 6'($urandom);
            nx_aed  = 6'($urandom);
            nx_pd0  = ($urandom_range(0, 5) == 0);
            nx_pd1  = ($urandom_range(0, 5) == 0);
            if (vc0_q.size() < 6 && $urandom_range(0, 2) == 0) add0_q.push_back(6'($urandom));
            if (vc1_q.size() < 6 && $urandom_range(0, 2) == 0) add1_q.push_back(6'($urandom));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
